q_measure: RTL and testbench
============================

// Module: q_measure
// PURPOSE
//   Produces the measured_q / ready pair consumed by the current-reference bisection controller.
//   Watches i_ref and restarts a measurement whenever it changes.
//   After a settling delay, averages 2**LOG2_AVG ADC samples and publishes the mean as measured_q.
//   Sits between the sensor ADC front-end and the control loop.
// PARAMETERS
//   WIDTH          10   data width of i_ref, adc_data, measured_q
//   LOG2_AVG       4    log2 of samples averaged per measurement (1..8)
//   SETTLE_CYCLES  64   clk cycles waited after an i_ref change before sampling (>=1)
// PORTS
//   clk         input   1          system clock, rising edge
//   rst         input   1          asynchronous active-low reset
//   enable      input   1          1 = measure; 0 = abort, go IDLE
//   i_ref       input   WIDTH      current reference under test
//   adc_valid   input   1          adc_data qualifier, one sample per high cycle
//   adc_data    input   WIDTH      unsigned Q sample
//   measured_q  output  WIDTH      latest averaged Q, held between updates
//   q_valid     output  1          1-cycle pulse when measured_q updates
//   ready       output  1          level: at least one valid measurement since enable rose
// BEHAVIOUR
//   Reset (rst=0, async):
//     - state=IDLE; measured_q=0, q_valid=0, ready=0.
//     - Accumulator, sample count, settle count and i_ref_q all 0.
//   States IDLE -> SETTLE -> ACCUM -> DONE -> SETTLE ...
//     IDLE:   enable=1 -> SETTLE. On entry: i_ref_q<=i_ref, settle_cnt<=0.
//     SETTLE: settle_cnt counts every cycle. ADC samples ignored.
//             At SETTLE_CYCLES-1 -> ACCUM; acc<=0, n<=0.
//     ACCUM:  each adc_valid cycle: acc+=adc_data, n+=1.
//             The cycle n reaches 2**LOG2_AVG: measured_q<=acc>>LOG2_AVG, -> DONE.
//             The final sample is included in that mean.
//     DONE:   1 cycle. q_valid=1, ready<=1. Then -> SETTLE, new i_ref_q capture.
//             Result: continuous back-to-back measurements.
//   i_ref change: detected as i_ref != i_ref_q, sampled every cycle in SETTLE/ACCUM/DONE.
//     - Action: i_ref_q<=i_ref, settle_cnt<=0, go SETTLE; a partial ACCUM is discarded.
//     - ready and measured_q are unchanged (stale value is held).
//     - Change in the same cycle as the final sample: the change wins. No update, no q_valid.
//   enable=0 in any state: -> IDLE next cycle, ready<=0. measured_q is held, q_valid=0.
//   Arithmetic:
//     - acc is WIDTH+LOG2_AVG bits unsigned, so it cannot overflow.
//     - Mean is truncated (floor), never rounded.
//     - All-ones input gives measured_q = 2**WIDTH-1.
//   Latency: first q_valid arrives >= SETTLE_CYCLES + 2**LOG2_AVG + 1 cycles after enable rises.
//     This minimum is met with adc_valid held at 1.
//   adc_valid gaps: stall ACCUM only. No timeout.
//   Outputs are registered; no combinational path from input to output.
// STRUCTURE
//   q_meas_pkg:
//     - state encoding: IDLE=2'd0, SETTLE=2'd1, ACCUM=2'd2, DONE=2'd3.
//     - clog2 helper for settle counter width.
//   Sub-module q_accumulator (clear, add_en, data, sum, count, full):
//     - holds acc and the sample counter.
//     - FSM, i_ref tracking and output registers stay in q_measure.
// TESTING
//   1. Reset mid-ACCUM (rst=0 one cycle) -> all outputs 0 same cycle; IDLE afterwards.
//   2. WIDTH=10, LOG2_AVG=4, SETTLE=64, adc_valid=1, adc_data=500 -> q_valid at cycle 81, measured_q=500, ready=1.
//   3. Samples alternating 100/101 x16 -> measured_q=100 (floor of 100.5).
//   4. i_ref 300->301 after 10 ACCUM samples -> no q_valid for >=80 cycles; old measured_q held; ready stays 1.
//   5. adc_valid every 3rd cycle, data=1023 -> q_valid 64+48+1 cycles after enable; measured_q=1023, no overflow.
//   6. enable dropped during DONE -> ready=0 next cycle; re-enable -> full SETTLE restarts.

Source files
------------

// File: rtl/q_meas_pkg.sv
// Shared types for the Q measurement block: FSM encoding and a width helper.
package q_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/q_accumulator.sv
// Sample accumulator: running sum and count of ADC samples for one measurement.
module q_accumulator #(
  parameter int WIDTH    = 10,
  parameter int LOG2_AVG = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      add_en,
  input  logic [WIDTH-1:0]          data,
  output logic [WIDTH+LOG2_AVG-1:0] sum,
  output logic [LOG2_AVG:0]         count,
  output logic                      full
);
  localparam int AW = WIDTH + LOG2_AVG;
  localparam logic [LOG2_AVG:0] LAST = (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);

  logic [AW-1:0] acc;

  // sum already includes this cycle's sample so the mean is ready on the final add
  assign sum  = acc + (add_en ? {{LOG2_AVG{1'b0}}, data} : '0);
  assign full = add_en && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (add_en) begin
      acc   <= sum;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/q_measure.sv
// Settle-then-average Q measurement, restarted whenever i_ref moves.
module q_measure
  import q_meas_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int LOG2_AVG      = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  output logic [WIDTH-1:0] measured_q,
  output logic             q_valid,
  output logic             ready
);
  localparam int SW = (clog2(SETTLE_CYCLES) < 1) ? 1 : clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t                    state, state_nxt;
  logic [WIDTH-1:0]          i_ref_q;
  logic [SW-1:0]             settle_cnt;
  logic [WIDTH+LOG2_AVG-1:0] sum;
  logic [LOG2_AVG:0]         cnt_unused;
  logic                      last, chg, restart, publish;

  assign chg     = (state != IDLE) && (i_ref != i_ref_q);
  assign restart = enable && ((state == IDLE) || (state == DONE) || chg);
  // an i_ref change on the final sample discards the measurement
  assign publish = enable && (state == ACCUM) && last && !chg;

  q_accumulator #(.WIDTH(WIDTH), .LOG2_AVG(LOG2_AVG)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ACCUM),
    .add_en ((state == ACCUM) && adc_valid),
    .data   (adc_data),
    .sum    (sum),
    .count  (cnt_unused),
    .full   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
    if (chg)     state_nxt = SETTLE;
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_ref_q    <= '0;
      settle_cnt <= '0;
      measured_q <= '0;
      q_valid    <= 1'b0;
      ready      <= 1'b0;
    end else begin
      q_valid <= publish;
      if (restart) begin
        i_ref_q    <= i_ref;
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (publish) measured_q <= sum[WIDTH+LOG2_AVG-1:LOG2_AVG];
      if (!enable)      ready <= 1'b0;
      else if (publish) ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_q_measure.sv
// Randomised and directed bench for q_measure against a sample-list reference model.
module tb_q_measure;
  localparam int W = 10, L = 4, SETTLE = 64, NAVG = 16;

  logic         clk = 1'b0, rst = 1'b0, en = 1'b0, av = 1'b0;
  logic [W-1:0] iref = '0, ad = '0;
  logic [W-1:0] mq;
  logic         qv, rdy;

  always #5 clk = ~clk;

  q_measure #(.WIDTH(W), .LOG2_AVG(L), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .enable(en), .i_ref(iref), .adc_valid(av),
    .adc_data(ad), .measured_q(mq), .q_valid(qv), .ready(rdy)
  );

  int n_vec = 0, n_err = 0;
  int k = 0, k0 = 0, first_qv = -1, lat = -1;

  // reference: phase 0 idle, 1 settling, 2 collecting, 3 just published
  int m_phase = 0, m_wait = 0, m_ref = 0, m_q = 0;
  bit m_qv = 0, m_rdy = 0;
  int smp[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_ref = 0; m_q = 0; m_qv = 0; m_rdy = 0;
    smp.delete();
  endtask

  task automatic model_update();
    int s;
    m_qv = 0;
    if (!en) begin
      m_phase = 0; m_rdy = 0; smp.delete();
    end else if (m_phase == 0 || m_phase == 3 || int'(iref) != m_ref) begin
      m_ref = int'(iref); m_wait = 0; m_phase = 1; smp.delete();
    end else if (m_phase == 1) begin
      m_wait++;
      if (m_wait == SETTLE) begin m_phase = 2; smp.delete(); end
    end else if (av) begin
      smp.push_back(int'(ad));
      if (smp.size() == NAVG) begin
        s = 0;
        foreach (smp[i]) s += smp[i];
        m_q = s / NAVG; m_qv = 1; m_rdy = 1; m_phase = 3;
      end
    end
  endtask

  task automatic step(input logic e, input logic [W-1:0] r, input logic v, input logic [W-1:0] d);
    en = e; iref = r; av = v; ad = d;
    k++;
    @(posedge clk);
    model_update();
    #1;
    chk("q_valid", 32'(qv), 32'(m_qv));
    chk("ready", 32'(rdy), 32'(m_rdy));
    chk("measured_q", 32'(mq), 32'(m_q));
    if (qv && first_qv < 0) first_qv = k;
  endtask

  // mode 0: constant, 1: alternating d/d+1, 2: valid every third cycle
  task automatic run_qv(input logic [W-1:0] r, input int mode, input int dval, input int maxc);
    int rel;
    logic v;
    logic [W-1:0] d;
    k0 = k; first_qv = -1; lat = -1;
    for (int i = 0; i < maxc && first_qv < 0; i++) begin
      rel = i + 1;
      v = (mode == 2) ? (rel % 3 == 2) : 1'b1;
      d = (mode == 1 && rel % 2 == 1) ? W'(dval + 1) : W'(dval);
      step(1'b1, r, v, d);
    end
    if (first_qv < 0) chk("qv_timeout", 0, 1);
    else lat = first_qv - k0;
  endtask

  task automatic run_to_samples(input logic [W-1:0] r, input int nsmp, input logic [W-1:0] d);
    for (int i = 0; i < 400 && !(m_phase == 2 && smp.size() == nsmp); i++)
      step(1'b1, r, 1'b1, d);
    if (!(m_phase == 2 && smp.size() == nsmp)) chk("accum_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] rr;
    model_reset();
    #12;
    chk("rst_mq", 32'(mq), 0);
    chk("rst_qv", 32'(qv), 0);
    chk("rst_rdy", 32'(rdy), 0);
    @(negedge clk) rst = 1'b1;

    // constant 500, adc_valid held
    run_qv(10'd300, 0, 500, 200);
    chk("lat_const", lat, 81);
    chk("mq_const", 32'(mq), 500);
    chk("rdy_const", 32'(rdy), 1);

    // alternating 100/101 floors to 100
    step(1'b0, 10'd300, 1'b0, 10'd0);
    run_qv(10'd300, 1, 100, 200);
    chk("lat_alt", lat, 81);
    chk("mq_alt", 32'(mq), 100);

    // i_ref change after 10 samples: stale result and ready held, full restart
    run_to_samples(10'd300, 10, 10'd700);
    run_qv(10'd301, 0, 700, 300);
    chk("lat_chg", lat, 81);
    chk("mq_chg", 32'(mq), 700);
    chk("rdy_chg", 32'(rdy), 1);

    // sparse full-scale samples
    step(1'b0, 10'd300, 1'b0, 10'd0);
    run_qv(10'd300, 2, 1023, 300);
    chk("lat_sparse", lat, 113);
    chk("mq_sparse", 32'(mq), 1023);

    // enable dropped in DONE, then re-enabled
    step(1'b0, 10'd300, 1'b1, 10'd5);
    chk("rdy_drop", 32'(rdy), 0);
    run_qv(10'd300, 0, 200, 200);
    chk("lat_reen", lat, 81);
    chk("mq_reen", 32'(mq), 200);

    // change coincident with the final sample wins
    run_to_samples(10'd300, 15, 10'd9);
    step(1'b1, 10'd301, 1'b1, 10'd9);
    chk("coinc_qv", 32'(qv), 0);
    chk("coinc_mq", 32'(mq), 200);
    run_qv(10'd301, 0, 9, 200);
    chk("mq_after_coinc", 32'(mq), 9);

    // async reset mid-accumulation
    run_to_samples(10'd301, 5, 10'd33);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("arst_mq", 32'(mq), 0);
    chk("arst_qv", 32'(qv), 0);
    chk("arst_rdy", 32'(rdy), 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    run_qv(10'd301, 0, 42, 200);
    chk("lat_post_rst", lat, 81);
    chk("mq_post_rst", 32'(mq), 42);

    // random traffic
    rr = 10'd512;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) rr = W'($urandom);
      step($urandom_range(0, 199) != 0, rr, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 10'h3FF : W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
